ram_dp_clr: RTL and testbench

RAM_DP_CLR -- requirements
Module: ram_dp_clr

---
 rtl/ram_dp_clr.sv | 75 +++++++
 tb/tb_ram_dp_clr.sv | 138 +++++++++++++
 2 files changed

// File: rtl/ram_dp_clr.sv
// ram_dp_clr: simple dual-port RAM with byte enables, registered read and a sequential clear engine.
module ram_dp_clr #(
  parameter int AW         = 3,
  parameter int DW         = 16,
  parameter int RDW_MODE   = 0,
  parameter int CLR_ON_RST = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  output logic            busy,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [DW-1:0]   wdata,
  input  logic [DW/8-1:0] wbe,
  input  logic            re,
  input  logic [AW-1:0]   raddr,
  output logic [DW-1:0]   rdata,
  output logic            rvalid
);
  localparam int NPOS = 2**AW;
  localparam int NBE  = DW/8;
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;
  localparam logic [0:0] S_RST   = (CLR_ON_RST != 0) ? S_CLEAR : S_IDLE;
  logic [0:0]    r_state;
  logic [AW-1:0] r_clr_ptr;
  logic [DW-1:0] r_mem [NPOS];
  logic [DW-1:0] r_rdata;
  logic          r_rvalid;
  logic [DW-1:0] w_merged;
  logic          w_go;
  logic          w_wr;
  logic          w_rd;
  logic          w_rdw;
  assign w_go  = (r_state == S_IDLE) && !clr;
  assign w_wr  = w_go && we;
  assign w_rd  = w_go && re;
  assign w_rdw = (RDW_MODE != 0) && w_wr && (waddr == raddr);
  assign busy   = (r_state == S_CLEAR);
  assign rdata  = r_rdata;
  assign rvalid = r_rvalid;
  always_comb begin
    w_merged = r_mem[waddr];
    for (int b = 0; b < NBE; b++)
      w_merged[8*b +: 8] = wbe[b] ? wdata[8*b +: 8] : r_mem[waddr][8*b +: 8];
  end
  // Storage has no reset; it is only touched outside reset by the clear engine or a user write.
  always_ff @(posedge clk) begin
    if (!rst && r_state == S_CLEAR)
      r_mem[r_clr_ptr] <= '0;
    else if (!rst && w_wr)
      r_mem[waddr] <= w_merged;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_RST;
      r_clr_ptr <= '0;
      r_rdata   <= '0;
      r_rvalid  <= 1'b0;
    end else begin
      r_rvalid <= w_rd;
      if (w_rd)
        r_rdata <= w_rdw ? w_merged : r_mem[raddr];
      if (r_state == S_CLEAR) begin
        r_clr_ptr <= r_clr_ptr + 1'b1;
        if (&r_clr_ptr)
          r_state <= S_IDLE;
      end else if (clr) begin
        r_state   <= S_CLEAR;
        r_clr_ptr <= '0;
      end
    end
  end
endmodule

// File: tb/tb_ram_dp_clr.sv
// tb_ram_dp_clr: directed and random checks of both read-during-write modes against a behavioural memory model.
module tb_ram_dp_clr;
  logic        clk = 0, rst = 0, clr = 0, we = 0, re = 0;
  logic [2:0]  waddr = 0, raddr = 0;
  logic [15:0] wdata = 0;
  logic [1:0]  wbe = 0;
  logic        busy0, busy1, rv0, rv1;
  logic [15:0] rd0, rd1;
  int          checks = 0, failures = 0;
  logic [15:0] m [8];
  int          bcnt = 0;
  logic [15:0] e_rd0 = 0, e_rd1 = 0;
  logic        e_rv = 0;
  always #5 clk = ~clk;
  ram_dp_clr #(.AW(3), .DW(16), .RDW_MODE(0), .CLR_ON_RST(1)) u0 (
    .clk(clk), .rst(rst), .clr(clr), .busy(busy0), .we(we), .waddr(waddr), .wdata(wdata),
    .wbe(wbe), .re(re), .raddr(raddr), .rdata(rd0), .rvalid(rv0));
  ram_dp_clr #(.AW(3), .DW(16), .RDW_MODE(1), .CLR_ON_RST(1)) u1 (
    .clk(clk), .rst(rst), .clr(clr), .busy(busy1), .we(we), .waddr(waddr), .wdata(wdata),
    .wbe(wbe), .re(re), .raddr(raddr), .rdata(rd1), .rvalid(rv1));
  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d, input logic [1:0] be);
    return {be[1] ? d[15:8] : old[15:8], be[0] ? d[7:0] : old[7:0]};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // Reference: a busy countdown, an array memory and the read/write rules applied to the pre-edge inputs.
  task automatic model();
    logic [15:0] nw;
    if (rst) begin
      bcnt = 8; e_rv = 0; e_rd0 = 0; e_rd1 = 0;
    end else if (bcnt > 0) begin
      m[8 - bcnt] = 0; bcnt--; e_rv = 0;
    end else if (clr) begin
      bcnt = 8; e_rv = 0;
    end else begin
      nw = merge(m[waddr], wdata, wbe);
      e_rv = re;
      if (re) begin
        e_rd0 = m[raddr];
        e_rd1 = (we && waddr == raddr) ? nw : m[raddr];
      end
      if (we) m[waddr] = nw;
    end
  endtask
  task automatic cyc(input string tag);
    model();
    @(posedge clk);
    #1;
    chk({tag, ".busy0"}, 32'(busy0), 32'(bcnt > 0));
    chk({tag, ".busy1"}, 32'(busy1), 32'(bcnt > 0));
    chk({tag, ".rv0"}, 32'(rv0), 32'(e_rv));
    chk({tag, ".rv1"}, 32'(rv1), 32'(e_rv));
    chk({tag, ".rd0"}, 32'(rd0), 32'(e_rd0));
    chk({tag, ".rd1"}, 32'(rd1), 32'(e_rd1));
  endtask
  task automatic wr(input logic [2:0] a, input logic [15:0] d, input logic [1:0] be);
    we = 1; waddr = a; wdata = d; wbe = be;
    cyc("wr");
    we = 0;
  endtask
  task automatic rd(input logic [2:0] a, input string tag);
    re = 1; raddr = a;
    cyc(tag);
    re = 0;
  endtask
  initial begin
    #2 rst = 1;
    #1;
    chk("rst_busy", 32'(busy0), 32'd1);
    chk("rst_rvalid", 32'(rv0), 32'd0);
    chk("rst_rdata", 32'(rd1), 32'd0);
    cyc("rst_hold");
    cyc("rst_hold");
    rst = 0;
    for (int i = 0; i < 8; i++) cyc("init_clear");
    for (int i = 0; i < 8; i++) rd(3'(i), "init_read");
    cyc("rvalid_drop");
    wr(3'd5, 16'hABCD, 2'b11);
    wr(3'd5, 16'h1234, 2'b01);
    rd(3'd5, "byte_en");
    chk("byte_en_val", 32'(rd0), 32'h0000AB34);
    wr(3'd6, 16'hFFFF, 2'b00);
    rd(3'd6, "be_none");
    wr(3'd2, 16'h1111, 2'b11);
    we = 1; waddr = 2; wdata = 16'h5555; wbe = 2'b11; re = 1; raddr = 2;
    cyc("rdw");
    we = 0; re = 0;
    chk("rdw_old", 32'(rd0), 32'h1111);
    chk("rdw_new", 32'(rd1), 32'h5555);
    we = 1; waddr = 4; wdata = 16'h00EE; wbe = 2'b11; re = 1; raddr = 5;
    cyc("rw_diff");
    we = 0; re = 0;
    for (int i = 1; i <= 3; i++) wr(3'(i), 16'(i), 2'b11);
    for (int i = 1; i <= 3; i++) begin
      re = 1; raddr = 3'(i);
      cyc("b2b");
      chk("b2b_val", 32'(rd0), 32'(i));
    end
    re = 0;
    cyc("b2b_drop");
    wr(3'd3, 16'h7777, 2'b11);
    clr = 1; we = 1; waddr = 3; wdata = 16'h9999; wbe = 2'b11;
    cyc("clr_start");
    we = 0; re = 1; raddr = 3;
    for (int i = 0; i < 8; i++) cyc("clr_busy");
    clr = 0; re = 0;
    rd(3'd3, "clr_after");
    chk("clr_val", 32'(rd0), 32'd0);
    for (int i = 0; i < 8; i++) wr(3'(i), 16'hC0DE + 16'(i), 2'b11);
    clr = 1;
    cyc("abort_start");
    clr = 0;
    for (int i = 0; i < 4; i++) cyc("abort_run");
    rst = 1;
    #1;
    chk("abort_busy", 32'(busy0), 32'd1);
    chk("abort_rdata", 32'(rd0), 32'd0);
    cyc("abort_rst");
    rst = 0;
    for (int i = 0; i < 8; i++) cyc("abort_clear");
    for (int i = 0; i < 8; i++) rd(3'(i), "abort_read");
    for (int n = 0; n < 300; n++) begin
      we = 1'($urandom_range(0, 1)); re = 1'($urandom_range(0, 1));
      waddr = 3'($urandom); raddr = ($urandom_range(0, 3) == 0) ? waddr : 3'($urandom);
      wdata = 16'($urandom); wbe = 2'($urandom);
      clr = ($urandom_range(0, 31) == 0);
      cyc("rand");
    end
    we = 0; re = 0; clr = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
